// File: rtl/jesd204_rx_release_pkg.sv
// Shared state encoding for the JESD204 RX elastic-buffer release controller.
package jesd204_rx_release_pkg;

   localparam int unsigned STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      WAIT_LOCK  = 3'd0,
      WAIT_READY = 3'd1,
      WAIT_LMFC  = 3'd2,
      DELAY      = 3'd3,
      RELEASED   = 3'd4
   } release_state_t;

endpackage

// File: rtl/jesd204_rx_lane_reduce.sv
// Masked AND-reduction of per-lane lock and ready; an empty enable mask never reports all-lanes.
module jesd204_rx_lane_reduce #(
   parameter int unsigned NUM_LANES = 4
) (
   input  logic [NUM_LANES-1:0] lane_lock,
   input  logic [NUM_LANES-1:0] lane_ready_n,
   input  logic [NUM_LANES-1:0] lane_disable,
   output logic                 lock_all,
   output logic                 rdy_all
);

   logic [NUM_LANES-1:0] en;
   logic                 any_en;

   always_comb begin
      en       = ~lane_disable;
      any_en   = |en;
      lock_all = any_en && (&(lane_lock | lane_disable));
      rdy_all  = any_en && ~|(lane_ready_n & en);
   end

endmodule

// File: rtl/jesd204_rx_buffer_release_ctrl.sv
// Sequences elastic-buffer release for all RX lanes, aligned to LMFC plus a programmable delay.
// Optional lane-skew monitor: define JESD204_RX_RELEASE_SKEW_MON_EN.
module jesd204_rx_buffer_release_ctrl
   import jesd204_rx_release_pkg::*;
#(
   parameter int unsigned NUM_LANES     = 4,
   parameter int unsigned DELAY_WIDTH   = 8,
   parameter int unsigned TIMEOUT_WIDTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_LANES-1:0]     lane_emb_lock,
   input  logic [NUM_LANES-1:0]     lane_buffer_ready_n,
   input  logic                     lmfc_edge,
   input  logic [NUM_LANES-1:0]     cfg_lanes_disable,
   input  logic [DELAY_WIDTH-1:0]   cfg_buffer_delay,
   input  logic [TIMEOUT_WIDTH-1:0] cfg_ready_timeout,
   output logic                     all_buffer_ready_n,
   output logic                     buffer_release_n,
   output logic                     event_timeout,
   output logic                     event_lane_drop,
   output logic [STATE_W-1:0]       status_state,
   output logic [DELAY_WIDTH-1:0]   status_lane_skew
);

   localparam logic [DELAY_WIDTH-1:0]   DLY_ONE = DELAY_WIDTH'(1);
   localparam logic [TIMEOUT_WIDTH-1:0] TO_ONE  = TIMEOUT_WIDTH'(1);

   release_state_t             state;
   logic                       lock_all;
   logic                       rdy_all;
   logic                       link_ok;
   logic [DELAY_WIDTH-1:0]     delay_cnt;
   logic [TIMEOUT_WIDTH-1:0]   timeout_cnt;
   logic [TIMEOUT_WIDTH-1:0]   timeout_next;

   jesd204_rx_lane_reduce #(
      .NUM_LANES (NUM_LANES)
   ) u_lane_reduce (
      .lane_lock    (lane_emb_lock),
      .lane_ready_n (lane_buffer_ready_n),
      .lane_disable (cfg_lanes_disable),
      .lock_all     (lock_all),
      .rdy_all      (rdy_all)
   );

   always_comb begin
      link_ok      = lock_all && rdy_all;
      timeout_next = (timeout_cnt == '1) ? timeout_cnt : timeout_cnt + TO_ONE;
   end

   assign status_state = state;

   // buffer_release_n is computed from the next state so it tracks RELEASED with no extra lag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state              <= WAIT_LOCK;
         all_buffer_ready_n <= 1'b1;
         buffer_release_n   <= 1'b1;
         event_timeout      <= 1'b0;
         event_lane_drop    <= 1'b0;
         delay_cnt          <= '0;
         timeout_cnt        <= '0;
      end else begin
         all_buffer_ready_n <= ~rdy_all;
         buffer_release_n   <= 1'b1;
         event_timeout      <= 1'b0;
         event_lane_drop    <= 1'b0;
         case (state)
            WAIT_LOCK: begin
               timeout_cnt <= '0;
               if (lock_all)
                  state <= WAIT_READY;
            end
            WAIT_READY: begin
               if (!lock_all) begin
                  state <= WAIT_LOCK;
               end else if (rdy_all) begin
                  state <= WAIT_LMFC;
               end else if (lmfc_edge) begin
                  timeout_cnt <= timeout_next;
                  if (cfg_ready_timeout != '0 && timeout_next == cfg_ready_timeout) begin
                     event_timeout <= 1'b1;
                     state         <= WAIT_LOCK;
                  end
               end
            end
            WAIT_LMFC: begin
               if (!link_ok) begin
                  state <= WAIT_LOCK;
               end else if (lmfc_edge) begin
                  if (cfg_buffer_delay == '0) begin
                     state            <= RELEASED;
                     buffer_release_n <= 1'b0;
                  end else begin
                     delay_cnt <= cfg_buffer_delay - DLY_ONE;
                     state     <= DELAY;
                  end
               end
            end
            DELAY: begin
               if (!link_ok) begin
                  state <= WAIT_LOCK;
               end else if (delay_cnt == '0) begin
                  state            <= RELEASED;
                  buffer_release_n <= 1'b0;
               end else begin
                  delay_cnt <= delay_cnt - DLY_ONE;
               end
            end
            RELEASED: begin
               if (!link_ok) begin
                  event_lane_drop <= 1'b1;
                  state           <= WAIT_LOCK;
               end else begin
                  buffer_release_n <= 1'b0;
               end
            end
            default: state <= WAIT_LOCK;
         endcase
      end
   end

`ifdef JESD204_RX_RELEASE_SKEW_MON_EN
   logic [DELAY_WIDTH-1:0] skew_cnt;
   logic [DELAY_WIDTH-1:0] skew_max;
   logic                   skew_run;
   logic                   any_rdy;

   assign any_rdy = |(~lane_buffer_ready_n & ~cfg_lanes_disable);

   // Once the first lane is ready the counter keeps running even if that lane wavers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         skew_cnt <= '0;
         skew_max <= '0;
         skew_run <= 1'b0;
      end else if (state == WAIT_READY) begin
         if (rdy_all) begin
            if (lock_all && skew_cnt > skew_max)
               skew_max <= skew_cnt;
         end else if (skew_run || any_rdy) begin
            skew_run <= 1'b1;
            if (skew_cnt != '1)
               skew_cnt <= skew_cnt + DLY_ONE;
         end
      end else begin
         skew_cnt <= '0;
         skew_run <= 1'b0;
      end
   end

   assign status_lane_skew = skew_max;
`else
   assign status_lane_skew = '0;
`endif

endmodule

// File: tb/tb_jesd204_rx_buffer_release_ctrl.sv
// Directed and randomized bench for jesd204_rx_buffer_release_ctrl against a lane-counting reference model.
module tb_jesd204_rx_buffer_release_ctrl;

   localparam int unsigned NL = 4;
   localparam int unsigned DW = 8;
   localparam int unsigned TW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [NL-1:0] lane_emb_lock = '0;
   logic [NL-1:0] lane_buffer_ready_n = '1;
   logic          lmfc_edge = 1'b0;
   logic [NL-1:0] cfg_lanes_disable = '0;
   logic [DW-1:0] cfg_buffer_delay = '0;
   logic [TW-1:0] cfg_ready_timeout = '0;
   logic          all_buffer_ready_n;
   logic          buffer_release_n;
   logic          event_timeout;
   logic          event_lane_drop;
   logic [2:0]    status_state;
   logic [DW-1:0] status_lane_skew;

   always #5 clk = ~clk;

   jesd204_rx_buffer_release_ctrl #(
      .NUM_LANES     (NL),
      .DELAY_WIDTH   (DW),
      .TIMEOUT_WIDTH (TW)
   ) dut (
      .clk                 (clk),
      .reset               (reset),
      .lane_emb_lock       (lane_emb_lock),
      .lane_buffer_ready_n (lane_buffer_ready_n),
      .lmfc_edge           (lmfc_edge),
      .cfg_lanes_disable   (cfg_lanes_disable),
      .cfg_buffer_delay    (cfg_buffer_delay),
      .cfg_ready_timeout   (cfg_ready_timeout),
      .all_buffer_ready_n  (all_buffer_ready_n),
      .buffer_release_n    (buffer_release_n),
      .event_timeout       (event_timeout),
      .event_lane_drop     (event_lane_drop),
      .status_state        (status_state),
      .status_lane_skew    (status_lane_skew)
   );

   int n_vec = 0;
   int n_err = 0;

   // reference model: phase numbers, absolute release beat, first-ready beat
   int     m_phase, m_to, m_first, m_skew;
   longint m_beat = 0, m_due;
   bit     e_abr_n, e_rel_n, e_to, e_drop;

   // observation markers, beats in absolute model time
   longint abr_fall, rel_fall, rel_rise, to_beat, drop_beat;
   int     n_to, n_drop, n_state_nz, n_abr_low, n_rel_low;
   bit     last_abr, last_rel;

   task automatic check_val(input string tag, input longint got, input longint exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (beat %0d)", tag, got, exp, m_beat);
      end
   endtask

   function automatic int exp_skew();
`ifdef JESD204_RX_RELEASE_SKEW_MON_EN
      return m_skew;
`else
      return 0;
`endif
   endfunction

   task automatic model_step();
      int  n_en = 0, n_lock = 0, n_rdy = 0, span;
      bit  lock_all, rdy_all, ok;
      for (int i = 0; i < NL; i++) begin
         if (!cfg_lanes_disable[i]) begin
            n_en++;
            if (lane_emb_lock[i]) n_lock++;
            if (!lane_buffer_ready_n[i]) n_rdy++;
         end
      end
      lock_all = (n_en > 0) && (n_lock == n_en);
      rdy_all  = (n_en > 0) && (n_rdy == n_en);
      ok       = lock_all && rdy_all;
      e_abr_n  = !rdy_all;
      e_to     = 1'b0;
      e_drop   = 1'b0;

      if (m_phase == 1) begin
         if (rdy_all) begin
            if (lock_all) begin
               span = (m_first < 0) ? 0 : int'(m_beat - m_first);
               if (span > 255) span = 255;
               if (span > m_skew) m_skew = span;
            end
         end else if (m_first < 0 && n_rdy > 0) begin
            m_first = int'(m_beat);
         end
      end else begin
         m_first = -1;
      end

      case (m_phase)
         0: begin
            m_to = 0;
            if (lock_all) m_phase = 1;
         end
         1: begin
            if (!lock_all) m_phase = 0;
            else if (rdy_all) m_phase = 2;
            else if (lmfc_edge) begin
               m_to = (m_to < 15) ? m_to + 1 : 15;
               if (cfg_ready_timeout != 0 && m_to == int'(cfg_ready_timeout)) begin
                  e_to    = 1'b1;
                  m_phase = 0;
               end
            end
         end
         2: begin
            if (!ok) m_phase = 0;
            else if (lmfc_edge) begin
               m_due   = m_beat + longint'(cfg_buffer_delay);
               m_phase = (cfg_buffer_delay == 0) ? 4 : 3;
            end
         end
         3: begin
            if (!ok) m_phase = 0;
            else if (m_beat == m_due) m_phase = 4;
         end
         4: begin
            if (!ok) begin
               e_drop  = 1'b1;
               m_phase = 0;
            end
         end
         default: m_phase = 0;
      endcase
      e_rel_n = (m_phase != 4);
      m_beat++;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check_val("state", status_state, m_phase);
      check_val("all_ready_n", all_buffer_ready_n, e_abr_n);
      check_val("release_n", buffer_release_n, e_rel_n);
      check_val("ev_timeout", event_timeout, e_to);
      check_val("ev_lane_drop", event_lane_drop, e_drop);
      check_val("lane_skew", status_lane_skew, exp_skew());
      if (last_abr && !all_buffer_ready_n) abr_fall = m_beat;
      if (last_rel && !buffer_release_n) rel_fall = m_beat;
      if (!last_rel && buffer_release_n) rel_rise = m_beat;
      if (event_timeout) begin n_to++; to_beat = m_beat; end
      if (event_lane_drop) begin n_drop++; drop_beat = m_beat; end
      if (status_state != 0) n_state_nz++;
      if (!all_buffer_ready_n) n_abr_low++;
      if (!buffer_release_n) n_rel_low++;
      last_abr = all_buffer_ready_n;
      last_rel = buffer_release_n;
   endtask

   // Called at posedge+1; asserts reset between edges and checks outputs before any clock.
   task automatic apply_reset();
      #2 reset = 1'b1;
      #1;
      check_val("rst_state", status_state, 0);
      check_val("rst_all_ready_n", all_buffer_ready_n, 1);
      check_val("rst_release_n", buffer_release_n, 1);
      check_val("rst_ev_timeout", event_timeout, 0);
      check_val("rst_ev_lane_drop", event_lane_drop, 0);
      check_val("rst_lane_skew", status_lane_skew, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      m_phase = 0; m_to = 0; m_first = -1; m_skew = 0;
      abr_fall = -1; rel_fall = -1; rel_rise = -1; to_beat = -1; drop_beat = -1;
      n_to = 0; n_drop = 0; n_state_nz = 0; n_abr_low = 0; n_rel_low = 0;
      last_abr = 1'b1; last_rel = 1'b1;
   endtask

   initial begin
      longint base;
      int     rb[NL];
      int     lk[NL];
      int     rd[NL];
      int     period, ph, want_skew;

      // staggered lane readiness, release five beats after the LMFC edge
      apply_reset();
      cfg_buffer_delay = 8'd5;
      rb = '{10, 12, 15, 20};
      base = m_beat;
      for (int b = 0; b < 60; b++) begin
         lane_emb_lock = '1;
         for (int i = 0; i < NL; i++) lane_buffer_ready_n[i] = !(b >= rb[i]);
         lmfc_edge = (b == 40);
         tick();
      end
      lmfc_edge = 1'b0;
`ifdef JESD204_RX_RELEASE_SKEW_MON_EN
      want_skew = 10;
`else
      want_skew = 0;
`endif
      check_val("abr_fall_beat", abr_fall - base, 21);
      check_val("release_fall_beat", rel_fall - base, 46);
      check_val("skew_directed", status_lane_skew, want_skew);

      // zero delay: release on the beat after the LMFC edge
      apply_reset();
      cfg_buffer_delay = '0;
      base = m_beat;
      for (int b = 0; b < 14; b++) begin
         lane_emb_lock = '1;
         lane_buffer_ready_n = '0;
         lmfc_edge = (b == 7);
         tick();
      end
      lmfc_edge = 1'b0;
      check_val("zero_delay_fall", rel_fall - base, 8);

      // lane 2 never ready, timeout after three LMFC edges
      apply_reset();
      cfg_ready_timeout = 4'd3;
      base = m_beat;
      for (int b = 0; b < 30; b++) begin
         lane_emb_lock = '1;
         lane_buffer_ready_n = 4'b0100;
         lmfc_edge = ((b % 8) == 5);
         tick();
      end
      lmfc_edge = 1'b0;
      check_val("timeout_pulses", n_to, 1);
      check_val("timeout_beat", to_beat - base, 22);
      check_val("timeout_no_release", n_rel_low, 0);

      // single-beat lock loss on lane 1 while released
      apply_reset();
      cfg_ready_timeout = '0;
      cfg_buffer_delay = 8'd2;
      base = m_beat;
      for (int b = 0; b < 16; b++) begin
         lane_emb_lock = (b == 10) ? 4'b1101 : 4'b1111;
         lane_buffer_ready_n = '0;
         lmfc_edge = (b == 3);
         tick();
      end
      lmfc_edge = 1'b0;
      check_val("drop_release_fall", rel_fall - base, 6);
      check_val("drop_pulses", n_drop, 1);
      check_val("drop_beat", drop_beat - base, 11);
      check_val("drop_release_rise", rel_rise - base, 11);

      // disabled lane 2 without lock is ignored
      apply_reset();
      cfg_lanes_disable = 4'b0100;
      cfg_buffer_delay = 8'd1;
      base = m_beat;
      for (int b = 0; b < 12; b++) begin
         lane_emb_lock = 4'b1011;
         lane_buffer_ready_n = 4'b0100;
         lmfc_edge = (b == 4);
         tick();
      end
      lmfc_edge = 1'b0;
      check_val("masked_release_fall", rel_fall - base, 6);

      // every lane disabled: nothing ever progresses
      apply_reset();
      cfg_lanes_disable = '1;
      for (int b = 0; b < 20; b++) begin
         lane_emb_lock = '1;
         lane_buffer_ready_n = '0;
         lmfc_edge = ((b % 5) == 2);
         tick();
      end
      lmfc_edge = 1'b0;
      check_val("all_disabled_state", n_state_nz, 0);
      check_val("all_disabled_abr", n_abr_low, 0);

      // asynchronous reset in the middle of a long delay
      apply_reset();
      cfg_lanes_disable = '0;
      cfg_buffer_delay = 8'd30;
      for (int b = 0; b < 10; b++) begin
         lane_emb_lock = '1;
         lane_buffer_ready_n = '0;
         lmfc_edge = (b == 2);
         tick();
      end
      lmfc_edge = 1'b0;
      check_val("mid_delay_state", status_state, 3);
      apply_reset();

      // randomized episodes
      for (int ep = 0; ep < 25; ep++) begin
         lane_emb_lock = '0;
         lmfc_edge = 1'b0;
         tick();
         tick();
         cfg_lanes_disable = ($urandom_range(0, 3) == 0) ? NL'($urandom) : '0;
         cfg_buffer_delay  = DW'($urandom_range(0, 12));
         cfg_ready_timeout = TW'($urandom_range(0, 5));
         period = $urandom_range(4, 16);
         ph     = $urandom_range(0, period - 1);
         for (int i = 0; i < NL; i++) begin
            lk[i] = $urandom_range(0, 6);
            rd[i] = ($urandom_range(0, 7) == 0) ? 1000 : $urandom_range(0, 30);
         end
         for (int b = 0; b < 80; b++) begin
            for (int i = 0; i < NL; i++) begin
               lane_emb_lock[i]       = (b >= lk[i]) && ($urandom_range(0, 99) != 0);
               lane_buffer_ready_n[i] = !(b >= rd[i]) || ($urandom_range(0, 149) == 0);
            end
            lmfc_edge = ((b % period) == ph);
            tick();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/jesd204_rx_buffer_release_ctrl.md
Name: jesd204_rx_buffer_release_ctrl

Overview:
Multi-lane controller that sequences the elastic-buffer release for all 64b/66b RX lanes of a link.
- Monitors per-lane extended-multiblock lock and buffer-ready.
- Drives the shared all_buffer_ready_n and buffer_release_n signals back to every lane.
- Times the release to an LMFC edge plus a programmable delay, giving deterministic latency.
- Sits in the link-layer top, between the lane instances and the LMFC generator.

Parameters:
NUM_LANES, 4, number of RX lanes supervised (1..32)
DELAY_WIDTH, 8, width of the release delay counter in clk beats
TIMEOUT_WIDTH, 4, width of the ready-timeout counter in LMFC periods

Ports:
clk  input  1  link clock, all logic rising-edge
reset  input  1  asynchronous, active-high reset
lane_emb_lock  input  NUM_LANES  per-lane extended multiblock lock
lane_buffer_ready_n  input  NUM_LANES  per-lane buffer not-ready (0 = writing)
lmfc_edge  input  1  single-cycle LMFC boundary pulse
cfg_lanes_disable  input  NUM_LANES  1 = lane excluded from all decisions
cfg_buffer_delay  input  DELAY_WIDTH  beats from LMFC edge to release
cfg_ready_timeout  input  TIMEOUT_WIDTH  LMFC edges allowed in WAIT_READY; 0 = no timeout
all_buffer_ready_n  output  1  registered OR of enabled lane_buffer_ready_n
buffer_release_n  output  1  0 = all lanes read their buffers
event_timeout  output  1  one-cycle pulse, ready timeout expired
event_lane_drop  output  1  one-cycle pulse, lane lost lock/ready while released
status_state  output  3  current FSM state encoding
status_lane_skew  output  DELAY_WIDTH  max first-to-last lane-ready spread in beats (optional feature)

Behaviour:
- Reset (async assert, sync deassert) values:
  - state = WAIT_LOCK
  - all_buffer_ready_n = 1, buffer_release_n = 1
  - events = 0, counters = 0, status_lane_skew = 0
- en = ~cfg_lanes_disable.
- lock_all = &(lane_emb_lock | ~en) and en != 0.
- rdy_all = ~|(lane_buffer_ready_n & en) and en != 0.
- all_buffer_ready_n <= ~rdy_all each cycle (1-cycle latency). Forced 1 when en == 0.
- FSM, all outputs registered:
  - WAIT_LOCK (0): go to WAIT_READY when lock_all. Clear the timeout counter.
  - WAIT_READY (1):
    - !lock_all -> WAIT_LOCK.
    - rdy_all -> WAIT_LMFC.
    - Otherwise increment the timeout counter on each lmfc_edge. When cfg_ready_timeout != 0 and the counter reaches it on an lmfc_edge: pulse event_timeout, go to WAIT_LOCK.
  - WAIT_LMFC (2):
    - Loss of lock_all or rdy_all -> WAIT_LOCK.
    - On lmfc_edge with cfg_buffer_delay == 0 -> RELEASED.
    - On lmfc_edge otherwise: load delay_cnt = cfg_buffer_delay - 1, go to DELAY.
  - DELAY (3): decrement delay_cnt each cycle; at 0 -> RELEASED. Loss of lock_all or rdy_all -> WAIT_LOCK.
  - RELEASED (4): buffer_release_n = 0 while in state. Loss of lock_all or rdy_all -> pulse event_lane_drop, go to WAIT_LOCK.
- Release timing: buffer_release_n falls exactly cfg_buffer_delay+1 cycles after the lmfc_edge cycle. It rises the cycle after the FSM leaves RELEASED.
- Priority in any state: loss of lock/ready beats lmfc_edge and timeout in the same cycle.
- Configuration changes are sampled live. Software changes them only in WAIT_LOCK.
- Timeout counter saturates at all-ones and never wraps.
- Undefined state encodings return to WAIT_LOCK.

Optional Feature:
JESD204_RX_RELEASE_SKEW_MON_EN
- Defined:
  - In WAIT_READY, a beat counter starts on the first cycle any enabled lane shows ready_n = 0. It stops when rdy_all.
  - status_lane_skew <= max(status_lane_skew, count), saturating at all-ones.
  - Cleared only by reset.
- Undefined: status_lane_skew is tied to 0 and no counter logic is generated.

Decomposition:
- Package jesd204_rx_release_pkg holds:
  - the state enum constants (WAIT_LOCK=0, WAIT_READY=1, WAIT_LMFC=2, DELAY=3, RELEASED=4);
  - the 3-bit state width constant.
- Sub-module jesd204_rx_lane_reduce: purely combinational mask-and-reduce of lock/ready vectors, producing lock_all and rdy_all. It is reused by the TX-side sync controller.

Test Plan:
- NUM_LANES=4, lock all lanes, ready lanes at beats 10/12/15/20, lmfc_edge at beat 40, delay=5 -> all_buffer_ready_n falls at beat 21; buffer_release_n falls at beat 46; status_lane_skew = 10 with the macro defined.
- cfg_buffer_delay=0, rdy_all, lmfc_edge at beat N -> buffer_release_n = 0 at beat N+1.
- Lane 2 never ready, cfg_ready_timeout=3 -> event_timeout pulses on the 3rd lmfc_edge; state returns to WAIT_LOCK; buffer_release_n stays 1.
- In RELEASED, drop lane_emb_lock[1] for 1 cycle -> event_lane_drop pulses once; buffer_release_n = 1 next cycle; FSM re-walks WAIT_LOCK -> WAIT_READY.
- cfg_lanes_disable=4'b0100 with lane 2 lock=0 -> release proceeds normally. cfg_lanes_disable=4'b1111 -> FSM stays in WAIT_LOCK and all_buffer_ready_n = 1.
- Assert reset asynchronously mid-DELAY -> all outputs return to reset values immediately without a clock edge; status_state = 0.
